// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : AXI4-Lite response codes and the initiator FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master
// Brief    : Single-outstanding AXI4-Lite initiator; one command in, one
//            response out. Optional macro AXIL_MASTER_ALIGN_CHECK_EN rejects
//            misaligned commands locally with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [REG_WIDTH-1:0]   cmd_wdata,
  input  logic [REG_WIDTH/8-1:0] cmd_wstrb,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [REG_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,

  output logic [ADDR_WIDTH-1:0]  AWADDR,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [REG_WIDTH-1:0]   WDATA,
  output logic [REG_WIDTH/8-1:0] WSTRB,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic                   BVALID,
  output logic                   BREADY,
  input  logic [1:0]             BRESP,

  output logic [ADDR_WIDTH-1:0]  ARADDR,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic [REG_WIDTH-1:0]   RDATA,
  input  logic                   RVALID,
  output logic                   RREADY,
  input  logic [1:0]             RRESP
);

  axil_mst_state_t        state_q;
  logic                   cmd_ready_q;
  logic [ADDR_WIDTH-1:0]  awaddr_q;
  logic                   awvalid_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [REG_WIDTH/8-1:0] wstrb_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic [ADDR_WIDTH-1:0]  araddr_q;
  logic                   arvalid_q;
  logic                   rready_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic                   rsp_valid_q;
  logic                   rsp_write_q;
  logic [REG_WIDTH-1:0]   rsp_rdata_q;
  resp_t                  rsp_resp_q;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic cmd_misaligned;

  assign aw_hs  = awvalid_q & AWREADY;
  assign w_hs   = wvalid_q  & WREADY;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q  | w_hs;

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
  localparam int LSB_W = $clog2(REG_WIDTH/8);
  assign cmd_misaligned = |cmd_addr[LSB_W-1:0];
`else
  assign cmd_misaligned = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            rsp_write_q <= cmd_write;
            if (cmd_misaligned) begin
              rsp_rdata_q <= '0;
              rsp_resp_q  <= SLVERR;
              state_q     <= RSP;
            end else if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end

        // AW and W retire independently; leave only once both have handshaked.
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (BVALID) begin
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= resp_t'(BRESP);
            state_q     <= RSP;
          end
        end

        RD_REQ: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (RVALID) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= resp_t'(RRESP);
            state_q     <= RSP;
          end
        end

        // rsp_valid rises one cycle after entering RSP, then holds until taken.
        RSP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master
// Brief    : Scoreboard bench for axi_lite_master against a delay-configurable
//            behavioural AXI-Lite slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

  localparam int RW = 32;
  localparam int AW = 32;
  localparam int SW = RW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [RW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [RW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [RW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  axi_lite_master #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Slave knobs: cycles of wait before each READY/VALID, and returned values.
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [RW-1:0] r_data_v = '0;

  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_wait, r_wait;
  logic aw_now, w_now;

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID  && (w_cnt  >= w_dly);
  assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
  assign BVALID  = b_wait  && (b_cnt  >= b_dly);
  assign RVALID  = r_wait  && (r_cnt  >= r_dly);
  assign BRESP   = BVALID ? b_resp_v : 2'b00;
  assign RRESP   = RVALID ? r_resp_v : 2'b00;
  assign RDATA   = RVALID ? r_data_v : '0;
  assign aw_now  = AWVALID && AWREADY;
  assign w_now   = WVALID && WREADY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 1'b0; r_wait <= 1'b0;
    end else begin
      aw_cnt <= aw_now ? 0 : (AWVALID ? aw_cnt + 1 : aw_cnt);
      w_cnt  <= w_now  ? 0 : (WVALID  ? w_cnt + 1  : w_cnt);
      ar_cnt <= (ARVALID && ARREADY) ? 0 : (ARVALID ? ar_cnt + 1 : ar_cnt);
      if ((aw_got || aw_now) && (w_got || w_now)) begin
        b_wait <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_now) aw_got <= 1'b1;
        if (w_now)  w_got  <= 1'b1;
      end
      if (BVALID && BREADY) begin b_wait <= 1'b0; b_cnt <= 0; end
      else if (b_wait) b_cnt <= b_cnt + 1;
      if (ARVALID && ARREADY) begin r_wait <= 1'b1; r_cnt <= 0; end
      else if (RVALID && RREADY) begin r_wait <= 1'b0; r_cnt <= 0; end
      else if (r_wait) r_cnt <= r_cnt + 1;
    end
  end

  typedef struct {
    logic          wr;
    logic [RW-1:0] rdata;
    logic [1:0]    resp;
    int            lat;
    int            t_acc;
  } rsp_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic [SW-1:0] strb;
  } wr_exp_t;

  rsp_exp_t      rsp_q[$];
  wr_exp_t       aw_q[$];
  wr_exp_t       w_q[$];
  logic [AW-1:0] ar_q[$];

  int n_wr_exp = 0, n_rd_exp = 0;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int viol = 0;
  int last_acc = 0;

  logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_rw;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [RW-1:0] p_wdata, p_rd;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_rs;
  rsp_exp_t      m_r;
  wr_exp_t       m_w;
  logic [AW-1:0] m_a;

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_awv && !p_awr && (!AWVALID || AWADDR != p_awaddr)) viol++;
      if (p_wv && !p_wr && (!WVALID || WDATA != p_wdata || WSTRB != p_wstrb)) viol++;
      if (p_arv && !p_arr && (!ARVALID || ARADDR != p_araddr)) viol++;
      if (p_rv && !p_rr && (!rsp_valid || rsp_write != p_rw || rsp_rdata != p_rd || rsp_resp != p_rs)) viol++;
      if (BREADY != b_wait || RREADY != r_wait) viol++;
      if (aw_now) begin
        aw_hs_n++;
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin m_w = aw_q.pop_front(); check("awaddr", AWADDR, m_w.addr); end
      end
      if (w_now) begin
        w_hs_n++;
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          m_w = w_q.pop_front();
          check("wdata", WDATA, m_w.data);
          check("wstrb", WSTRB, m_w.strb);
        end
      end
      if (ARVALID && ARREADY) begin
        ar_hs_n++;
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin m_a = ar_q.pop_front(); check("araddr", ARADDR, m_a); end
      end
      if (BVALID && BREADY) b_hs_n++;
      if (RVALID && RREADY) r_hs_n++;
      if (rsp_valid && !p_rv) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else if (rsp_q[0].lat >= 0) check("rsp_latency", cyc - rsp_q[0].t_acc, rsp_q[0].lat);
      end
      if (rsp_valid && rsp_ready && rsp_q.size() > 0) begin
        m_r = rsp_q.pop_front();
        check("rsp_write", rsp_write, m_r.wr);
        check("rsp_rdata", rsp_rdata, m_r.rdata);
        check("rsp_resp", rsp_resp, m_r.resp);
      end
      p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
      p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
      p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
      p_rv = rsp_valid; p_rr = rsp_ready; p_rw = rsp_write; p_rd = rsp_rdata; p_rs = rsp_resp;
    end else begin
      p_awv = 1'b0; p_awr = 1'b0; p_awaddr = '0; p_wv = 1'b0; p_wr = 1'b0;
      p_wdata = '0; p_wstrb = '0; p_arv = 1'b0; p_arr = 1'b0; p_araddr = '0;
      p_rv = 1'b0; p_rr = 1'b0; p_rw = 1'b0; p_rd = '0; p_rs = 2'b00;
    end
  end

  // Present one command; push its expected response (and AXI beats if issued).
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] data,
                      input logic [SW-1:0] strb, input logic [RW-1:0] exp_rdata,
                      input logic [1:0] exp_resp, input int lat, input logic issue);
    rsp_exp_t e;
    wr_exp_t  w;
    bit       ok;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e.wr = wr; e.rdata = wr ? '0 : exp_rdata; e.resp = exp_resp; e.lat = lat; e.t_acc = cyc + 1;
    last_acc = cyc + 1;
    rsp_q.push_back(e);
    if (issue) begin
      if (wr) begin
        w.addr = addr; w.data = data; w.strb = strb;
        aw_q.push_back(w); w_q.push_back(w);
        n_wr_exp++;
      end else begin
        ar_q.push_back(addr);
        n_rd_exp++;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (rsp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check("rsp_timeout", rsp_q.size(), 0);
      rsp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a;
    bit seen;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {AWVALID, WVALID, ARVALID, rsp_valid}, 4'b0000);
    check("rst_readies", {BREADY, RREADY}, 2'b00);
    check("rst_addr", {AWADDR, ARADDR}, 64'h0);
    check("rst_wdata_wstrb", {WDATA, WSTRB}, 36'h0);
    check("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'h0);
    @(posedge clk); #1;

    // Zero-wait write.
    send(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, '0, 2'b00, 3, 1'b1);
    wait_idle();

    // W completes three cycles ahead of AW.
    aw_dly = 3;
    send(1'b1, 32'h8, 32'h12345678, 4'hF, '0, 2'b00, 6, 1'b1);
    wait_idle();
    aw_dly = 0;
    check("b_count_after_writes", b_hs_n, 2);

    // Read with five wait cycles on R.
    r_dly = 5; r_data_v = 32'hCAFEF00D;
    send(1'b0, 32'h4, '0, '0, 32'hCAFEF00D, 2'b00, 8, 1'b1);
    wait_idle();
    r_dly = 0;

    // SLVERR write response held under rsp_ready backpressure.
    b_resp_v = 2'b10; rsp_ready = 1'b0;
    send(1'b1, 32'h10, 32'hA5A5A5A5, 4'h3, '0, 2'b10, 3, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("hold_rsp_seen", seen, 1);
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 32'hC; cmd_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_resp", rsp_resp, 2'b10);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_no_arvalid", ARVALID, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; b_resp_v = 2'b00; r_data_v = 32'h0BADF00D;
    send(1'b0, 32'hC, '0, '0, 32'h0BADF00D, 2'b00, 3, 1'b1);
    wait_idle();

    // Back-to-back reads: one command per five cycles.
    r_data_v = 32'h11112222;
    send(1'b0, 32'h14, '0, '0, 32'h11112222, 2'b00, 3, 1'b1);
    acc_a = last_acc;
    send(1'b0, 32'h18, '0, '0, 32'h11112222, 2'b00, 3, 1'b1);
    check("throughput", last_acc - acc_a, 5);
    wait_idle();

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    send(1'b1, 32'h2, 32'h55AA55AA, 4'hF, '0, 2'b10, 1, 1'b0);
    wait_idle();
    send(1'b0, 32'h5, '0, '0, '0, 2'b10, 1, 1'b0);
    wait_idle();
`else
    send(1'b1, 32'h2, 32'h55AA55AA, 4'hF, '0, 2'b00, 3, 1'b1);
    wait_idle();
`endif

    // Reset while stuck in WR_REQ.
    aw_dly = 20; w_dly = 20;
    send(1'b1, 32'h20, 32'hFFFF0000, 4'hF, '0, 2'b00, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valids", {AWVALID, WVALID, ARVALID, rsp_valid}, 4'b0000);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_aw_w", {AWADDR, WDATA, WSTRB}, 68'h0);
    check("arst_bready", BREADY, 0);
    rsp_q.delete();
    aw_dly = 0; w_dly = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r_data_v = 32'h13579BDF;
    send(1'b0, 32'h0, '0, '0, 32'h13579BDF, 2'b00, 3, 1'b1);
    wait_idle();

    @(negedge clk);
    check("protocol_violations", viol, 0);
    check("aw_total", aw_hs_n, n_wr_exp);
    check("w_total", w_hs_n, n_wr_exp);
    check("b_total", b_hs_n, n_wr_exp);
    check("ar_total", ar_hs_n, n_rd_exp);
    check("r_total", r_hs_n, n_rd_exp);
    check("pending_expect", aw_q.size() + w_q.size() + ar_q.size() + rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
